// File: rtl/branch_resolver.sv
// branch_resolver: in-order queue of fetch-time branch predictions checked
// against execute outcomes; flags mispredicts, redirects fetch and flushes.
module branch_resolver #(
    parameter int ADDR_W       = 64,
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pred_valid,
    input  logic              pred_taken,
    input  logic [ADDR_W-1:0] pred_target,
    input  logic [ADDR_W-1:0] pred_fallthru,
    output logic              pred_ready,
    input  logic              res_valid,
    input  logic              res_taken,
    input  logic [ADDR_W-1:0] res_target,
    output logic              mispredict,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush,
    output logic              upd_valid,
    output logic              upd_taken,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  miss_cnt,
    output logic              err_underflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [FC_W-1:0] FC_LAST  = FC_W'(FLUSH_CYCLES - 1);

    typedef enum logic {S_RUN, S_FLUSH} state_t;

    typedef struct packed {
        logic              taken;
        logic [ADDR_W-1:0] target;
        logic [ADDR_W-1:0] fallthru;
    } entry_t;

    entry_t           mem [DEPTH];
    state_t           state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [FC_W-1:0]  flush_left;

    entry_t head;
    logic   push;
    logic   resolve;
    logic   underflow;
    logic   miss;

    // Handshake and flush depend only on registered state, never on inputs.
    assign pred_ready = (state == S_RUN) && (count < FULL_CNT);
    assign flush      = (state == S_FLUSH);

    assign head      = mem[rd_ptr];
    assign push      = pred_valid && pred_ready;
    assign resolve   = (state == S_RUN) && res_valid && (count != '0);
    assign underflow = (state == S_RUN) && res_valid && (count == '0);
    assign miss      = resolve && ((res_taken != head.taken) ||
                                   (res_taken && (res_target != head.target)));

    // NOTE: the entry array carries no reset; occupancy lives in count and the
    // pointers, so stale slots are never read and the storage stays reset-free.
    always_ff @(posedge clk) begin
        if (push && !miss) begin
            mem[wr_ptr] <= '{taken: pred_taken, target: pred_target, fallthru: pred_fallthru};
        end
    end

    // NOTE: every register below is updated with <= so all of them see the
    // pre-edge values of each other, exactly like the flops they become.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_RUN;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            flush_left    <= '0;
            mispredict    <= 1'b0;
            redirect_pc   <= '0;
            upd_valid     <= 1'b0;
            upd_taken     <= 1'b0;
            branch_cnt    <= '0;
            miss_cnt      <= '0;
            err_underflow <= 1'b0;
        end else begin
            mispredict <= 1'b0;
            upd_valid  <= 1'b0;

            if (resolve) begin
                upd_valid <= 1'b1;
                upd_taken <= res_taken;
                if (branch_cnt != '1) branch_cnt <= branch_cnt + CNT_W'(1);
            end

            if (underflow) err_underflow <= 1'b1;

            if (miss) begin
                // Everything younger than the head is wrong-path, including a same-cycle push.
                mispredict  <= 1'b1;
                redirect_pc <= res_taken ? res_target : head.fallthru;
                if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                count       <= '0;
                state       <= S_FLUSH;
                flush_left  <= FC_LAST;
            end else begin
                if (push)    wr_ptr <= wr_ptr + PTR_W'(1);
                if (resolve) rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, resolve})
                    2'b10:   count <= count + (PTR_W + 1)'(1);
                    2'b01:   count <= count - (PTR_W + 1)'(1);
                    default: count <= count;
                endcase

                if (state == S_FLUSH) begin
                    if (flush_left == '0) state <= S_RUN;
                    else flush_left <= flush_left - FC_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: a reference model pushes expected
// outputs into a scoreboard at drive time; they are popped after each edge.
module tb_branch_resolver;
    localparam int ADDR_W       = 64;
    localparam int DEPTH        = 4;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              pred_valid = 1'b0;
    logic              pred_taken = 1'b0;
    logic [ADDR_W-1:0] pred_target = '0;
    logic [ADDR_W-1:0] pred_fallthru = '0;
    logic              pred_ready;
    logic              res_valid = 1'b0;
    logic              res_taken = 1'b0;
    logic [ADDR_W-1:0] res_target = '0;
    logic              mispredict;
    logic [ADDR_W-1:0] redirect_pc;
    logic              flush;
    logic              upd_valid;
    logic              upd_taken;
    logic [CNT_W-1:0]  branch_cnt;
    logic [CNT_W-1:0]  miss_cnt;
    logic              err_underflow;

    always #5 clk = ~clk;

    branch_resolver #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .pred_target(pred_target), .pred_fallthru(pred_fallthru),
        .pred_ready(pred_ready),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc), .flush(flush),
        .upd_valid(upd_valid), .upd_taken(upd_taken),
        .branch_cnt(branch_cnt), .miss_cnt(miss_cnt), .err_underflow(err_underflow)
    );

    typedef struct {
        logic        taken;
        logic [63:0] target;
        logic [63:0] ft;
    } pred_t;

    typedef struct {
        logic        upd_valid;
        logic        upd_taken;
        logic        mispredict;
        logic [63:0] redirect;
        logic        flush;
        logic [15:0] bcnt;
        logic [15:0] mcnt;
        logic        err;
    } exp_t;

    pred_t       mq[$];
    exp_t        sb[$];
    int          m_flush_left = 0;
    logic [15:0] m_bcnt = '0;
    logic [15:0] m_mcnt = '0;
    logic        m_err = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
            return;
        end
        e = sb.pop_front();
        check({tag, ":upd_valid"},  64'(upd_valid),     64'(e.upd_valid));
        check({tag, ":mispredict"}, 64'(mispredict),    64'(e.mispredict));
        check({tag, ":flush"},      64'(flush),         64'(e.flush));
        check({tag, ":branch_cnt"}, 64'(branch_cnt),    64'(e.bcnt));
        check({tag, ":miss_cnt"},   64'(miss_cnt),      64'(e.mcnt));
        check({tag, ":err"},        64'(err_underflow), 64'(e.err));
        if (e.upd_valid)  check({tag, ":upd_taken"}, 64'(upd_taken), 64'(e.upd_taken));
        if (e.mispredict) check({tag, ":redirect"},  redirect_pc,     e.redirect);
    endtask

    // One clock cycle: drive at negedge, predict, clock, compare at next negedge.
    task automatic step(input string tag,
                        input logic pv, input logic pt, input logic [63:0] ptgt, input logic [63:0] pft,
                        input logic rv, input logic rt, input logic [63:0] rtgt);
        exp_t  e;
        pred_t h;
        logic  fl_act, ready, rslv;
        pred_valid = pv; pred_taken = pt; pred_target = ptgt; pred_fallthru = pft;
        res_valid = rv;  res_taken = rt;  res_target = rtgt;

        fl_act = (m_flush_left > 0);
        ready  = !fl_act && (mq.size() < DEPTH);
        #1;
        check({tag, ":pred_ready"}, 64'(pred_ready), 64'(ready));

        e = '{default: 0};
        rslv = !fl_act && rv && (mq.size() > 0);
        if (!fl_act && rv && (mq.size() == 0)) m_err = 1'b1;
        if (rslv) begin
            h = mq.pop_front();
            e.upd_valid  = 1'b1;
            e.upd_taken  = rt;
            if (m_bcnt != 16'hFFFF) m_bcnt++;
            e.mispredict = (rt != h.taken) || (rt && (rtgt != h.target));
            e.redirect   = rt ? rtgt : h.ft;
        end
        if (e.mispredict) begin
            mq.delete();
            if (m_mcnt != 16'hFFFF) m_mcnt++;
            m_flush_left = FLUSH_CYCLES;
        end else begin
            if (pv && ready) mq.push_back('{taken: pt, target: ptgt, ft: pft});
            if (fl_act) m_flush_left--;
        end
        e.flush = (m_flush_left > 0);
        e.bcnt  = m_bcnt;
        e.mcnt  = m_mcnt;
        e.err   = m_err;
        sb.push_back(e);

        @(posedge clk);
        @(negedge clk);
        pred_valid = 1'b0;
        res_valid  = 1'b0;
        compare(tag);
    endtask

    task automatic push_pred(input string tag, input logic t, input logic [63:0] tgt, input logic [63:0] ft);
        step(tag, 1'b1, t, tgt, ft, 1'b0, 1'b0, 64'h0);
    endtask

    task automatic resolve(input string tag, input logic t, input logic [63:0] tgt);
        step(tag, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, t, tgt);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        pred_valid = 1'b0;
        res_valid  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mq.delete();
        m_flush_left = 0;
        m_bcnt = '0;
        m_mcnt = '0;
        m_err  = 1'b0;
        sb.push_back('{default: 0});
        compare(tag);
        check({tag, ":pred_ready"}, 64'(pred_ready), 64'h1);
    endtask

    initial begin
        logic        t;
        logic [63:0] tgt;

        do_reset("reset");

        // Correct taken prediction.
        push_pred("t1_push", 1'b1, 64'h100, 64'h48);
        resolve("t1_res", 1'b1, 64'h100);

        // Predicted not-taken, actually taken: redirect, flush, inputs ignored.
        push_pred("t2_push", 1'b0, 64'h300, 64'h48);
        resolve("t2_res", 1'b1, 64'h200);
        step("t2_fl1", 1'b1, 1'b1, 64'h500, 64'h504, 1'b1, 1'b1, 64'h500);
        step("t2_fl2", 1'b1, 1'b1, 64'h600, 64'h604, 1'b1, 1'b0, 64'h0);

        // Right direction, wrong target.
        push_pred("t3_push", 1'b1, 64'h100, 64'h48);
        resolve("t3_res", 1'b1, 64'h180);
        idle("t3_fl1");
        idle("t3_fl2");

        // Offset pointers by one, then fill, overflow push, drain across the wrap.
        push_pred("t4_pre", 1'b0, 64'h10, 64'h14);
        resolve("t4_pre_res", 1'b0, 64'h0);
        for (int i = 0; i < DEPTH; i++) begin
            t   = i[0];
            tgt = 64'h1000 + 64'(i) * 64'h10;
            push_pred("t4_fill", t, tgt, tgt + 64'h4);
        end
        push_pred("t4_drop", 1'b1, 64'h9999, 64'h999d);
        for (int i = 0; i < DEPTH; i++) begin
            t   = i[0];
            tgt = 64'h1000 + 64'(i) * 64'h10;
            if (i == 1) step("t4_push_res", 1'b1, 1'b1, 64'h7000, 64'h7004, 1'b1, t, tgt);
            else        resolve("t4_res", t, tgt);
        end
        resolve("t4_res_extra", 1'b1, 64'h7000);

        // Underflow is sticky until reset.
        do_reset("t5_reset");
        resolve("t5_underflow", 1'b0, 64'h0);
        idle("t5_hold");
        idle("t5_hold2");
        do_reset("t5_clear");

        // Mispredict discards younger entries and a same-cycle push.
        push_pred("t6_a", 1'b1, 64'h2000, 64'h1f04);
        push_pred("t6_b", 1'b0, 64'h2100, 64'h2004);
        push_pred("t6_c", 1'b1, 64'h2200, 64'h2104);
        step("t6_miss_push", 1'b1, 1'b1, 64'h2300, 64'h2204, 1'b1, 1'b0, 64'h0);
        idle("t6_fl1");
        idle("t6_fl2");
        resolve("t6_empty", 1'b1, 64'h2100);

        // Reset in the middle of a flush with a fresh queue afterwards.
        do_reset("t7_reset");
        push_pred("t7_a", 1'b0, 64'h3000, 64'h3004);
        push_pred("t7_b", 1'b1, 64'h3100, 64'h3104);
        resolve("t7_miss", 1'b1, 64'h3050);
        idle("t7_fl1");
        do_reset("t7_midflush");
        push_pred("t7_push", 1'b1, 64'h4000, 64'h4004);
        resolve("t7_res", 1'b1, 64'h4000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
